hpgp_ditl_ctrl: RTL and testbench

- Sequencer for the dual-port turbo de-interleaver RAM/ROM datapath (ram_dual).
- Two phases per physical block (PB):
  - WRITE: fills the RAM with 2-bit soft symbols in natural order.
  - READ: replays addresses 0..LEN-1 with the PB-mode ROM offset so the datapath returns de-interleaved symbols.
- Sits between the rx serial symbol stream and the turbo decoder input; owns all ram_dual control inputs.

---
 rtl/hpgp_ditl_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_hpgp_ditl_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpgp_ditl_ctrl.sv
// hpgp_ditl_ctrl: sequencer for the dual-port turbo de-interleaver RAM/ROM (ram_dual).
//   WRITE fills the RAM with soft symbols in natural order.
//   READ replays addresses 0..LEN-1 with the block-type ROM offset.
//   DRAIN waits for the last de-interleaved symbol.
//   DONE pulses 'done' for one cycle.
// Optional macro HPGP_DITL_CTRL_STATUS_EN adds the frame_cnt and ovf_err status outputs.
// Ports:
//   clk, rst (async, active-high)
//   start, pb_mode                          block request and block type
//   in_data, in_vld, in_rdy                 input symbol stream
//   ram_wdata, ram_waddr, ram_pb_offset,
//   ram_wen, ram_din_vld                    ram_dual controls
//   ram_dout_vld, ram_rdata_ditl            ram_dual read return
//   out_data, out_vld, out_last             de-interleaved stream (no back-pressure)
//   busy, done                              status
//   frame_cnt, ovf_err                      present only when HPGP_DITL_CTRL_STATUS_EN is defined
module hpgp_ditl_ctrl #(
    parameter int unsigned D_WIDTH = 2,
    parameter int unsigned A_WIDTH = 12,
    parameter int unsigned LEN0    = 544,
    parameter int unsigned LEN1    = 2080,
    parameter int unsigned LEN2    = 64,
    parameter int unsigned OFS0    = 0,
    parameter int unsigned OFS1    = 544,
    parameter int unsigned OFS2    = 2624
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         pb_mode,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_vld,
    output logic               in_rdy,
    output logic [D_WIDTH-1:0] ram_wdata,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic [A_WIDTH-1:0] ram_pb_offset,
    output logic               ram_wen,
    output logic               ram_din_vld,
    input  logic               ram_dout_vld,
    input  logic [D_WIDTH-1:0] ram_rdata_ditl,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_vld,
    output logic               out_last,
    output logic               busy,
`ifdef HPGP_DITL_CTRL_STATUS_EN
    output logic [15:0]        frame_cnt,
    output logic [0:0]         ovf_err,
`endif
    output logic               done
);

    localparam int unsigned ADDR_SPACE = 1 << A_WIDTH;

    // Every block type must fit inside the ROM address space.
    if ((LEN0 + OFS0 > ADDR_SPACE) || (LEN1 + OFS1 > ADDR_SPACE) ||
        (LEN2 + OFS2 > ADDR_SPACE)) begin : g_cfg_err
        $error("hpgp_ditl_ctrl: LEN + OFS exceeds the address space");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic [A_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [A_WIDTH-1:0] len_q, len_d;
    logic [A_WIDTH-1:0] ofs_d, waddr_d;
    logic [D_WIDTH-1:0] wdata_d, out_data_d;
    logic               wen_d, din_vld_d, out_vld_d, out_last_d;
    logic               in_rdy_d, busy_d, done_d;
    logic               wr_hs, rd_accept;
`ifdef HPGP_DITL_CTRL_STATUS_EN
    logic [15:0]        frame_d;
    logic               ovf_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        len_d      = len_q;
        ofs_d      = ram_pb_offset;
        waddr_d    = ram_waddr;
        wdata_d    = ram_wdata;
        wen_d      = 1'b0;
        din_vld_d  = 1'b0;
        out_data_d = out_data;
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
        wr_hs      = in_vld & in_rdy;
        // Returns beyond the block length are excess and are dropped.
        rd_accept  = ram_dout_vld & (rcnt_q < len_q);

        // Return path forwards independently of the sequencer state
        if (rd_accept) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_rdata_ditl;
            out_last_d = (rcnt_q == len_q - A_WIDTH'(1));
            rcnt_d     = rcnt_q + A_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start && (pb_mode != 2'd3)) begin
                    case (pb_mode)
                        2'd0:    begin len_d = A_WIDTH'(LEN0); ofs_d = A_WIDTH'(OFS0); end
                        2'd1:    begin len_d = A_WIDTH'(LEN1); ofs_d = A_WIDTH'(OFS1); end
                        default: begin len_d = A_WIDTH'(LEN2); ofs_d = A_WIDTH'(OFS2); end
                    endcase
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_hs) begin
                    wen_d   = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = in_data;
                    if (cnt_q == len_q - A_WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = S_READ;
                    end else begin
                        cnt_d = cnt_q + A_WIDTH'(1);
                    end
                end
            end
            S_READ: begin
                din_vld_d = 1'b1;
                waddr_d   = cnt_q;
                if (cnt_q == len_q - A_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + A_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (rcnt_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the upcoming state.
        in_rdy_d = (state_d == S_WRITE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);

`ifdef HPGP_DITL_CTRL_STATUS_EN
        frame_d = frame_cnt;
        ovf_d   = ovf_err[0];
        if (done_d) begin
            frame_d = frame_cnt + 16'd1;
        end
        if ((ram_dout_vld && !rd_accept) ||
            (in_vld && ((state_q == S_READ) || (state_q == S_DRAIN)))) begin
            ovf_d = 1'b1;
        end
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rcnt_q        <= '0;
            len_q         <= '0;
            ram_pb_offset <= '0;
            ram_waddr     <= '0;
            ram_wdata     <= '0;
            ram_wen       <= 1'b0;
            ram_din_vld   <= 1'b0;
            out_data      <= '0;
            out_vld       <= 1'b0;
            out_last      <= 1'b0;
            in_rdy        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef HPGP_DITL_CTRL_STATUS_EN
            frame_cnt     <= '0;
            ovf_err       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rcnt_q        <= rcnt_d;
            len_q         <= len_d;
            ram_pb_offset <= ofs_d;
            ram_waddr     <= waddr_d;
            ram_wdata     <= wdata_d;
            ram_wen       <= wen_d;
            ram_din_vld   <= din_vld_d;
            out_data      <= out_data_d;
            out_vld       <= out_vld_d;
            out_last      <= out_last_d;
            in_rdy        <= in_rdy_d;
            busy          <= busy_d;
            done          <= done_d;
`ifdef HPGP_DITL_CTRL_STATUS_EN
            frame_cnt     <= frame_d;
            ovf_err       <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_hpgp_ditl_ctrl.sv
// Testbench for hpgp_ditl_ctrl.
// It models ram_dual: a RAM plus a ROM permutation with a 2-cycle read latency.
// It predicts every output from a block timeline.
// That timeline is anchored on the start cycle S and the final input handshake cycle H.
module tb_hpgp_ditl_ctrl;

    localparam int unsigned D_WIDTH = 2;
    localparam int unsigned A_WIDTH = 12;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         pb_mode = 2'd0;
    logic [D_WIDTH-1:0] in_data = '0;
    logic               in_vld = 1'b0;
    logic               extra_vld = 1'b0;
    logic               in_rdy;
    logic [D_WIDTH-1:0] ram_wdata;
    logic [A_WIDTH-1:0] ram_waddr;
    logic [A_WIDTH-1:0] ram_pb_offset;
    logic               ram_wen;
    logic               ram_din_vld;
    logic               ram_dout_vld;
    logic [D_WIDTH-1:0] ram_rdata_ditl;
    logic [D_WIDTH-1:0] out_data;
    logic               out_vld;
    logic               out_last;
    logic               busy;
    logic               done;
`ifdef HPGP_DITL_CTRL_STATUS_EN
    logic [15:0]        frame_cnt;
    logic [0:0]         ovf_err;
`endif

    hpgp_ditl_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pb_mode        (pb_mode),
        .in_data        (in_data),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .ram_wdata      (ram_wdata),
        .ram_waddr      (ram_waddr),
        .ram_pb_offset  (ram_pb_offset),
        .ram_wen        (ram_wen),
        .ram_din_vld    (ram_din_vld),
        .ram_dout_vld   (ram_dout_vld),
        .ram_rdata_ditl (ram_rdata_ditl),
        .out_data       (out_data),
        .out_vld        (out_vld),
        .out_last       (out_last),
        .busy           (busy),
`ifdef HPGP_DITL_CTRL_STATUS_EN
        .frame_cnt      (frame_cnt),
        .ovf_err        (ovf_err),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    // ROM content: the in-block RAM index read for each absolute ROM address.
    function automatic logic [11:0] rom_abs(input int a);
        if (a < 544)       return 12'(((a * 7) + 3) % 544);
        else if (a < 2624) return 12'((((a - 544) * 7) + 3) % 2080);
        else if (a < 2688) return 12'((((a - 2624) * 7) + 3) % 64);
        return 12'd0;
    endfunction

    function automatic int len_of(input int md);
        case (md)
            0:       return 544;
            1:       return 2080;
            default: return 64;
        endcase
    endfunction

    function automatic int ofs_of(input int md);
        case (md)
            0:       return 0;
            1:       return 544;
            default: return 2624;
        endcase
    endfunction

    // ram_dual environment model
    logic [D_WIDTH-1:0] mem [0:4095];
    logic               p1_vld, p2_vld;
    logic [D_WIDTH-1:0] p1_d, p2_d;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_vld <= 1'b0;
            p2_vld <= 1'b0;
            p1_d   <= '0;
            p2_d   <= '0;
        end else begin
            p1_vld <= ram_din_vld;
            p1_d   <= mem[rom_abs(int'(ram_waddr) + int'(ram_pb_offset))];
            p2_vld <= p1_vld;
            p2_d   <= p1_d;
        end
    end

    assign ram_dout_vld   = p2_vld | extra_vld;
    assign ram_rdata_ditl = p2_d;

    // Reference model state
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    bit               active = 1'b0;
    bit               h_known = 1'b0;
    int               m = 0;
    int               L = 0;
    int               O = 0;
    int               S = 0;
    int               H = 0;
    int               wr_idx = 0;
    logic [D_WIDTH-1:0] sym [0:4095];
    bit               hs_q = 1'b0;
    int               hs_idx_q = 0;
    logic [D_WIDTH-1:0] hs_dat_q = '0;
    int               frames_exp = 0;
    bit               ovf_exp = 1'b0;
    bit               ovf_pend = 1'b0;
    int               n_wen = 0;
    int               n_out = 0;
    int               n_last = 0;
    int               n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_rdy"},   32'(in_rdy), 0);
        chk({tag, ".wdata"},    32'(ram_wdata), 0);
        chk({tag, ".waddr"},    32'(ram_waddr), 0);
        chk({tag, ".offset"},   32'(ram_pb_offset), 0);
        chk({tag, ".wen"},      32'(ram_wen), 0);
        chk({tag, ".din_vld"},  32'(ram_din_vld), 0);
        chk({tag, ".out_data"}, 32'(out_data), 0);
        chk({tag, ".out_vld"},  32'(out_vld), 0);
        chk({tag, ".out_last"}, 32'(out_last), 0);
        chk({tag, ".busy"},     32'(busy), 0);
        chk({tag, ".done"},     32'(done), 0);
`ifdef HPGP_DITL_CTRL_STATUS_EN
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, ".ovf_err"},   32'(ovf_err), 0);
`endif
    endtask

    // Per-cycle comparison of every output against the block timeline
    task automatic check_cycle();
        bit e_rdy, e_din, e_out, e_last, e_done, e_busy;
        int idx;
        if (rst) return;
        if (ovf_pend) begin
            ovf_exp  = 1'b1;
            ovf_pend = 1'b0;
        end
        if (active && h_known && (cyc > H + L + 5)) begin
            chk("blk_wen_count",  32'(n_wen), 32'(L));
            chk("blk_out_count",  32'(n_out), 32'(L));
            chk("blk_last_count", 32'(n_last), 1);
            chk("blk_done_count", 32'(n_done), 1);
            active = 1'b0;
        end
        if (active && h_known && (cyc == H + L + 5)) frames_exp++;
        e_rdy  = active && (cyc > S) && (wr_idx < L);
        e_din  = active && h_known && (cyc >= H + 2) && (cyc <= H + L + 1);
        e_out  = active && h_known && (cyc >= H + 5) && (cyc <= H + L + 4);
        e_last = e_out && (cyc == H + L + 4);
        e_done = active && h_known && (cyc == H + L + 5);
        e_busy = active && (cyc > S);

        chk("in_rdy", 32'(in_rdy), 32'(e_rdy));
        chk("busy",   32'(busy),   32'(e_busy));
        chk("done",   32'(done),   32'(e_done));
        chk("ram_wen", 32'(ram_wen), 32'(hs_q));
        if (hs_q) begin
            chk("wr_addr", 32'(ram_waddr), 32'(hs_idx_q));
            chk("wr_data", 32'(ram_wdata), 32'(hs_dat_q));
        end
        chk("din_vld", 32'(ram_din_vld), 32'(e_din));
        if (e_din) begin
            chk("rd_addr",   32'(ram_waddr), 32'(cyc - H - 2));
            chk("pb_offset", 32'(ram_pb_offset), 32'(O));
        end
        chk("out_vld",  32'(out_vld),  32'(e_out));
        chk("out_last", 32'(out_last), 32'(e_last));
        if (e_out) begin
            idx = int'(rom_abs(cyc - H - 5 + O));
            chk("out_data", 32'(out_data), 32'(sym[idx]));
            // Hand-computed permutation pins for the 64-symbol block
            if (m == 2 && cyc == H + 5)     chk("pin_m2_first", 32'(out_data), 32'(sym[3]));
            if (m == 2 && cyc == H + L + 4) chk("pin_m2_last",  32'(out_data), 32'(sym[60]));
        end
`ifdef HPGP_DITL_CTRL_STATUS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(frames_exp & 16'hFFFF));
        chk("ovf_err",   32'(ovf_err),   32'(ovf_exp));
`endif
        if (ram_wen)  n_wen++;
        if (out_vld)  n_out++;
        if (out_last) n_last++;
        if (done)     n_done++;
    endtask

    // Drive inputs for the current cycle and advance the model
    task automatic drive(input bit s, input int md, input bit v, input bit x);
        bit rdy;
        start     = 1'b0;
        pb_mode   = 2'd0;
        in_vld    = 1'b0;
        extra_vld = 1'b0;
        in_data   = D_WIDTH'($urandom);
        hs_q      = 1'b0;
        if (s) begin
            start   = 1'b1;
            pb_mode = 2'(md);
            if (!active && md < 3) begin
                active  = 1'b1;
                h_known = 1'b0;
                m       = md;
                L       = len_of(md);
                O       = ofs_of(md);
                S       = cyc;
                wr_idx  = 0;
                n_wen   = 0;
                n_out   = 0;
                n_last  = 0;
                n_done  = 0;
            end
        end
        rdy = active && (cyc > S) && (wr_idx < L);
        if (v && rdy) begin
            in_vld      = 1'b1;
            sym[wr_idx] = in_data;
            hs_q        = 1'b1;
            hs_idx_q    = wr_idx;
            hs_dat_q    = in_data;
            wr_idx++;
            if (wr_idx == L) begin
                H       = cyc;
                h_known = 1'b1;
            end
        end
        if (x) begin
            extra_vld = 1'b1;
            ovf_pend  = 1'b1;
        end
    endtask

    task automatic step(input bit s, input int md, input bit v, input bit x);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive(s, md, v, x);
    endtask

    // vmode: 0 = in_vld continuous, 1 = alternating 1/0, 2 = random
    task automatic run_block(input int md, input int vmode, input bit mid_start,
                             input bit chain, input int chain_md, input bit inject);
        int guard;
        bit chain_pend, mid_pend, v, s, x;
        int smd;
        step(1'b1, md, 1'b0, 1'b0);
        chain_pend = chain;
        mid_pend   = mid_start;
        guard      = 0;
        while (active && guard < 20000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc + 1) % 2) == 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s   = 1'b0;
            smd = 0;
            x   = 1'b0;
            if (mid_pend && wr_idx == 50) begin
                s        = 1'b1;
                smd      = 0;
                mid_pend = 1'b0;
            end
            if (chain_pend && h_known && (cyc + 1 == H + L + 6)) begin
                s          = 1'b1;
                smd        = chain_md;
                chain_pend = 1'b0;
            end
            if (inject && h_known && (cyc + 1 == H + L + 5)) x = 1'b1;
            step(s, smd, v, x);
            guard++;
        end
        chk("block_timeout", 32'(active), 0);
    endtask

    task automatic model_clear();
        active   = 1'b0;
        h_known  = 1'b0;
        hs_q     = 1'b0;
        ovf_exp  = 1'b0;
        ovf_pend = 1'b0;
        frames_exp = 0;
    endtask

    initial begin
        int guard;
        #1 rst = 1'b1;
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);
        chk_all_zero("reset");
        #2 rst = 1'b0;

        // Abort a PB136 block after 100 symbols are written
        step(1'b1, 0, 1'b0, 1'b0);
        guard = 0;
        while (wr_idx < 100 && guard < 1000) begin
            step(1'b0, 0, 1'b1, 1'b0);
            guard++;
        end
        step(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_reset");
        model_clear();
        repeat (2) step(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b0;

        // PB16 with continuous input
        run_block(2, 0, 1'b0, 1'b0, 0, 1'b0);
        // PB520 with alternating in_vld
        run_block(1, 1, 1'b0, 1'b0, 0, 1'b0);
        // Reserved mode is ignored
        step(1'b1, 3, 1'b0, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0, 1'b0);
        // PB136 with a stray start during WRITE
        run_block(0, 2, 1'b1, 1'b0, 0, 1'b0);
`ifdef HPGP_DITL_CTRL_STATUS_EN
        chk("frame_cnt_after3", 32'(frame_cnt), 3);
        chk("ovf_before",       32'(ovf_err), 0);
`endif
        // Back-to-back: PB136 then PB16 started the cycle after done
        run_block(0, 2, 1'b0, 1'b1, 2, 1'b0);
        // PB16 with an excess ram_dout_vld on the done cycle
        run_block(2, 2, 1'b0, 1'b0, 0, 1'b1);
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);
`ifdef HPGP_DITL_CTRL_STATUS_EN
        chk("ovf_set", 32'(ovf_err), 1);
`endif
        run_block(2, 0, 1'b0, 1'b0, 0, 1'b0);
`ifdef HPGP_DITL_CTRL_STATUS_EN
        chk("ovf_sticky",      32'(ovf_err), 1);
        chk("frame_cnt_final", 32'(frame_cnt), 7);
`endif
        #2 rst = 1'b1;
        #1 chk_all_zero("final_reset");
        model_clear();
        repeat (2) step(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
